// File: rtl/exec_sequencer_pkg.sv
// Shared INSTRUCTION package: decoded instruction classes, sequencer states
// and the fixed accept-to-writeback latency of the execute sequencer.
// Imported by exec_sequencer and by anything that talks to the decoder.
package INSTRUCTION;

  // Decoded instruction class presented by the decoder.
  typedef enum logic [2:0] {
    R_TYPE = 3'd0,
    I_TYPE = 3'd1,
    S_TYPE = 3'd2,
    B_TYPE = 3'd3,
    U_TYPE = 3'd4,
    J_TYPE = 3'd5
  } instruction_type;

  // Execute sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } seq_state_t;

  // Cycles from instruction accept to the regfile write strobe.
  localparam int unsigned SEQ_WB_LATENCY = 3;

endpackage

// File: rtl/exec_sequencer.sv
// Purpose : sequences one decoded R/I instruction through LOAD -> EXEC -> WB,
//           driving datapath buffer strobes, the operand mux and regfile write.
// Latency : accept-to-rf_write 3 cycles; back-to-back 1 instruction / 3 cycles.
// Backpr. : instr_ready only in IDLE and WB; decoder holds the instruction.
// Ports   : clock/reset (async active-low); instr_valid/instr_ready/
//           instr_type_in/rw_addr_in from the decoder; rw_addr, alubuf1_load,
//           alubuf2_load, immbuf_load, is_imm, rf_write to the datapath;
//           busy, illegal (sticky), retired (count of WB exits).
// Config  : SEQ_RETIRE_CNT_EN defined -> retired counter present; undefined ->
//           retired tied to 0.
module exec_sequencer
  import INSTRUCTION::*;
#(
  parameter int CNT_W = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  instruction_type instr_type_in,
  input  logic [4:0]      rw_addr_in,
  output logic [4:0]      rw_addr,
  output logic            alubuf1_load,
  output logic            alubuf2_load,
  output logic            immbuf_load,
  output logic            is_imm,
  output logic            rf_write,
  output logic            busy,
  output logic            illegal,
  output logic [CNT_W-1:0] retired
);

  seq_state_t      state;
  seq_state_t      state_nxt;
  instruction_type type_q;
  logic            handshake;
  logic            type_legal;

  assign instr_ready = (state == IDLE) || (state == WB);
  assign handshake   = instr_valid && instr_ready;
  assign type_legal  = (instr_type_in == R_TYPE) || (instr_type_in == I_TYPE);

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state. An unsupported class is accepted but never leaves IDLE,
  // so it costs exactly one cycle and produces no strobes.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (handshake && type_legal) state_nxt = LOAD;
      end
      LOAD: state_nxt = EXEC;
      EXEC: state_nxt = WB;
      WB: begin
        if (handshake && type_legal) state_nxt = LOAD;
        else                         state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode. Purely from state and latched fields, so a reset in any
  // state drops every strobe immediately.
  always_comb begin
    alubuf1_load = 1'b0;
    alubuf2_load = 1'b0;
    immbuf_load  = 1'b0;
    rf_write     = 1'b0;
    busy         = (state != IDLE);
    unique case (state)
      LOAD: begin
        alubuf1_load = 1'b1;
        alubuf2_load = (type_q == R_TYPE);
        immbuf_load  = (type_q == I_TYPE);
      end
      // x0 is hardwired zero: the slot is still used but nothing is written.
      WB:      rf_write = (rw_addr != 5'd0);
      default: ;
    endcase
  end

  // Per-instruction fields, captured only on a handshake so they stay
  // stable from LOAD through WB regardless of what the decoder presents.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rw_addr <= 5'd0;
      type_q  <= R_TYPE;
      is_imm  <= 1'b0;
      illegal <= 1'b0;
    end else if (handshake) begin
      rw_addr <= rw_addr_in;
      type_q  <= instr_type_in;
      is_imm  <= (instr_type_in == I_TYPE);
      if (!type_legal) illegal <= 1'b1;
    end
  end

`ifdef SEQ_RETIRE_CNT_EN
  // Counts every WB exit (x0 destinations included); wraps naturally.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      retired <= '0;
    end else if (state == WB) begin
      retired <= retired + 1'b1;
    end
  end
`else
  assign retired = '0;
`endif

endmodule

// File: doc/exec_sequencer.md
EXEC_SEQUENCER -- requirements
Module: exec_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-002 SHALL have port clock, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port instr_valid, input, 1: the decoder is presenting a decoded instruction.
REQ-005 SHALL have port instr_ready, output, 1: the sequencer accepts an instruction this cycle.
REQ-006 SHALL have port instr_type_in, input, INSTRUCTION::instruction_type: decoded instruction class.
REQ-007 SHALL have port rw_addr_in, input, 5: destination register of the presented instruction.
REQ-008 SHALL have port rw_addr, output, 5: latched destination register driven to the regfile.
REQ-009 SHALL have ports alubuf1_load, alubuf2_load, immbuf_load, output, 1 each: datapath buffer load strobes.
REQ-010 SHALL have port is_imm, output, 1: ALU operand-2 mux select; 1 = immediate.
REQ-011 SHALL have port rf_write, output, 1: regfile write strobe.
REQ-012 SHALL have port busy, output, 1: state is not IDLE.
REQ-013 SHALL have port illegal, output, 1: sticky flag, set when an unsupported type is accepted.
REQ-014 SHALL have port retired, output, CNT_W: count of instructions that completed WB.

Function
REQ-015 SHALL implement states IDLE, LOAD, EXEC, WB, encoded as an enum.
REQ-016 SHALL assert instr_ready only in IDLE and in WB.
REQ-017 Handshake SHALL be defined as instr_valid && instr_ready at the rising edge; on accept: latch rw_addr_in and the class, set is_imm = (type == I_TYPE), and go to LOAD.
REQ-018 LOAD SHALL last 1 cycle: alubuf1_load = 1; alubuf2_load = 1 for R_TYPE; immbuf_load = 1 for I_TYPE; then go to EXEC.
REQ-019 EXEC SHALL last 1 cycle with all strobes 0 and is_imm held; then go to WB.
REQ-020 WB SHALL last 1 cycle with rf_write = 1, except that rf_write is 0 when latched rw_addr == 0.
REQ-021 In WB, a handshake SHALL go to LOAD; otherwise the FSM SHALL go to IDLE.
REQ-022 Back-to-back throughput SHALL be 1 instruction per 3 cycles.
REQ-023 Accept-to-rf_write latency SHALL be 3 cycles.
REQ-024 An accepted type other than R_TYPE or I_TYPE SHALL:
- set illegal;
- skip LOAD, EXEC and WB, with no strobes;
- return to IDLE the next cycle;
- not increment retired.
REQ-025 retired SHALL increment by 1 on each WB exit, with x0 writes included, and wrap modulo 2^CNT_W.
REQ-026 rw_addr and is_imm SHALL remain stable from LOAD through WB, independent of the inputs.
REQ-027 instr_valid while not ready SHALL be ignored; the decoder holds the instruction.

Reset
REQ-028 Reset assertion SHALL, asynchronously:
- force IDLE;
- clear rw_addr, is_imm, illegal and retired;
- drive every strobe and busy to 0.
REQ-029 Reset asserted mid-instruction SHALL abort the instruction with no rf_write, including when reset is asserted in WB.
REQ-030 After reset deasserts, instr_ready SHALL be 1 at the first rising edge.

Configuration
REQ-031 Macro SEQ_RETIRE_CNT_EN defined SHALL include the retired counter per REQ-025.
REQ-032 Macro SEQ_RETIRE_CNT_EN undefined SHALL tie retired to 0 and remove its register; all other behaviour is unchanged.

Structure
REQ-033 The state enum and the constant SEQ_WB_LATENCY = 3 SHALL live in the shared INSTRUCTION package; instruction_type SHALL be reused from that package.
REQ-034 The block SHALL be one module with no sub-modules; the FSM and the output decode SHALL be separate always blocks.

Verification
REQ-035 R_TYPE accept at edge 0 with rw_addr_in = 5 -> must see:
- edge 1 (LOAD): alubuf1_load = 1, alubuf2_load = 1, is_imm = 0;
- edge 3 (WB): rf_write = 1, rw_addr = 5;
- retired = 1.
REQ-036 I_TYPE with rw_addr_in = 7 -> must see:
- LOAD: immbuf_load = 1, alubuf2_load = 0;
- is_imm = 1 through WB;
- rf_write = 1 in WB.
REQ-037 Three R_TYPE instructions with instr_valid held high -> must see:
- rf_write pulses spaced exactly 3 cycles apart;
- instr_ready high only in WB;
- retired = 3.
REQ-038 R_TYPE with rw_addr_in = 0 -> rf_write = 0 in WB, and retired still increments.
REQ-039 Unsupported type accepted -> must see:
- illegal = 1, sticky;
- no strobes;
- IDLE after 1 cycle;
- retired unchanged.
REQ-040 Reset pulsed low during EXEC -> must see:
- immediate IDLE and busy = 0;
- no rf_write;
- retired = 0;
- the next instruction completes normally.
